// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: main + skid entry with valid/ready handshake,
// synchronous flush, and bubble insertion on the control bundle when empty.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 24,
  parameter int unsigned       CTRL_W      = 4,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;

  // in_ready looks only at state and reset, so out_ready never reaches it combinationally.
  assign in_ready  = reset & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_BUBBLE;
  assign occupancy = 2'(state);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      // Payload registers are left untouched so out_data does not toggle.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (in_fire) begin
            state     <= TWO;
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state     <= ONE;
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random run
// checked against a FIFO scoreboard of accepted entries.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 24;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW),
    .CTRL_BUBBLE(4'b0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Advance one clock edge, updating the scoreboard from the inputs presented before it.
  task automatic tick();
    bit   mi, mo;
    ent_t e;
    mi = reset && in_valid && (sb.size() < 2);
    mo = reset && (sb.size() > 0) && out_ready;
    if (!reset) sb.delete();
    else begin
      if (mo) void'(sb.pop_front());
      if (flush) sb.delete();
      else if (mi) begin
        e.d = in_data;
        e.c = in_ctrl;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 24'hABCDEF; in_ctrl = 4'hF;
    flush = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== 4'h0) $display("FAIL reset_out_ctrl got %h want 0", out_ctrl); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy got %0d want 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_data !== 24'h0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
    reset = 1'b1; in_valid = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_ctrl = 4'b1101;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 24'(i);
      #1;
      n_total++;
      if ($isunknown(occupancy) || occupancy > 2'd1) $display("FAIL stream_occ i=%0d got %0d want <=1", i, occupancy);
      else n_pass++;
      n_total++;
      if (i == 1) begin
        if (out_valid !== 1'b0) $display("FAIL stream_first_valid got %b want 0", out_valid); else n_pass++;
      end else begin
        if (out_valid !== 1'b1 || out_data !== 24'(i - 1) || out_ctrl !== 4'b1101)
          $display("FAIL stream_out i=%0d got v=%b d=%h c=%b want v=1 d=%h c=1101", i, out_valid, out_data, out_ctrl, 24'(i - 1));
        else n_pass++;
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b1 || out_data !== 24'h10) $display("FAIL stream_last got v=%b d=%h want v=1 d=000010", out_valid, out_data); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) $display("FAIL stream_drain got v=%b c=%h want v=0 c=0", out_valid, out_ctrl); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'h3;
    in_data = 24'hA0A0A0; tick();
    in_data = 24'hB1B1B1; tick();
    in_data = 24'hC2C2C2;
    #1;
    n_total++; if (occupancy !== 2'd2) $display("FAIL bp_occ got %0d want 2", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_data !== 24'hA0A0A0) $display("FAIL bp_main got v=%b d=%h want v=1 d=a0a0a0", out_valid, out_data); else n_pass++;
    tick();
    n_total++; if (occupancy !== 2'd2 || out_data !== 24'hA0A0A0) $display("FAIL bp_hold got occ=%0d d=%h want occ=2 d=a0a0a0", occupancy, out_data); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_data !== 24'hB1B1B1 || occupancy !== 2'd1 || in_ready !== 1'b1) $display("FAIL bp_second got d=%h occ=%0d rdy=%b want d=b1b1b1 occ=1 rdy=1", out_data, occupancy, in_ready); else n_pass++;
    tick();
    n_total++; if (out_data !== 24'hC2C2C2 || occupancy !== 2'd1 || out_ctrl !== 4'h3) $display("FAIL bp_third got d=%h occ=%0d c=%h want d=c2c2c2 occ=1 c=3", out_data, occupancy, out_ctrl); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) $display("FAIL bp_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 4'h7;
    in_data = 24'hD3D3D3; tick();
    in_data = 24'hE4E4E4; tick();
    in_data = 24'hF5F5F5; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_ctrl !== 4'h0) $display("FAIL flush_ctrl got %h want 0", out_ctrl); else n_pass++;
    n_total++; if (occupancy !== 2'd0) $display("FAIL flush_occ got %0d want 0", occupancy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else n_pass++;
    // Flush from ONE while a new entry is actually accepted: that entry must vanish too.
    in_valid = 1'b1; in_data = 24'h161616; tick();
    in_data = 24'h272727; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) $display("FAIL flush_one_in got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) $display("FAIL flush_absent got v=%b c=%h want v=0 c=0", out_valid, out_ctrl); else n_pass++;
  endtask

  task automatic test_flush_out_fire();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h383838; in_ctrl = 4'h9;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b1 || out_data !== 24'h383838) $display("FAIL ff_present got v=%b d=%h want v=1 d=383838", out_valid, out_data); else n_pass++;
    tick();
    flush = 1'b0;
    n_total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 4'h0) $display("FAIL ff_empty got occ=%0d v=%b c=%h want 0 0 0", occupancy, out_valid, out_ctrl); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = 24'($urandom);
      in_ctrl   = 4'($urandom);
      #1;
      n_total++;
      if (occupancy !== 2'(sb.size()) || out_valid !== (sb.size() != 0))
        $display("FAIL rnd_occ n=%0d got occ=%0d v=%b want occ=%0d", n, occupancy, out_valid, sb.size());
      else n_pass++;
      n_total++;
      if (in_ready !== (reset && sb.size() < 2)) $display("FAIL rnd_in_ready n=%0d got %b want %b", n, in_ready, (reset && sb.size() < 2));
      else n_pass++;
      n_total++;
      if (sb.size() == 0) begin
        if (out_ctrl !== 4'h0) $display("FAIL rnd_bubble n=%0d got c=%h want 0", n, out_ctrl); else n_pass++;
      end else begin
        if (out_data !== sb[0].d || out_ctrl !== sb[0].c)
          $display("FAIL rnd_order n=%0d got d=%h c=%h want d=%h c=%h", n, out_data, out_ctrl, sb[0].d, sb[0].c);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_out_fire();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register for the 8-bit pipelined MIPS datapath. It replaces the fixed-width inter-stage latches with one reusable block that carries a datapath bundle and a control bundle and supports valid/ready back-pressure through a 2-entry skid buffer. It also supports a synchronous flush and automatic bubble insertion, in which control is forced to a no-write value whenever the stage is empty. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 24, width of datapath bundle (e.g. ALU result, B operand, shifter output concatenated)
- CTRL_W, 4, width of control bundle (e.g. mem_write, reg_write, reg_write_mux)
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control value presented whenever out_valid=0; must encode "no memory write, no register write"
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (reset=0 at a rising edge resets the block)
- in_valid  input  1  upstream stage presents a valid entry
- in_ready  output  1  block can accept an entry this cycle
- in_data  input  DATA_W  upstream datapath bundle
- in_ctrl  input  CTRL_W  upstream control bundle
- flush  input  1  synchronous kill of all held entries (branch/jump squash)
- out_valid  output  1  out_data/out_ctrl hold a valid entry
- out_ready  input  1  downstream stage consumes the entry this cycle
- out_data  output  DATA_W  datapath bundle to next stage
- out_ctrl  output  CTRL_W  control bundle to next stage; CTRL_BUBBLE when out_valid=0
- occupancy  output  2  number of held entries (0, 1, 2)

## Operation
- Storage: main register (drives outputs) and skid register, each DATA_W+CTRL_W bits plus valid.
- State machine on occupancy: EMPTY(0), ONE(1), TWO(2).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = reset & (state != TWO); it depends only on state and reset, never combinationally on out_ready.
- out_valid = (state != EMPTY).
- Transitions, with no flush:
  - EMPTY: in_fire -> ONE, main <= in.
  - ONE: in_fire & out_fire -> ONE, main <= in. in_fire only -> TWO, skid <= in. out_fire only -> EMPTY.
  - TWO: out_fire -> ONE, main <= skid. Otherwise hold.
- Ordering is strict FIFO; no entry is duplicated or lost except by flush.
- flush=1: next state EMPTY and both entries discarded. An in_fire in the same cycle is also discarded. An out_fire in the same cycle counts as consumed by downstream.
- Bubble: whenever out_valid=0, out_ctrl = CTRL_BUBBLE. out_data is don't-care but holds its last registered value, with no toggling.
- Reset (reset=0 at edge) overrides flush and all inputs: state EMPTY, out_valid=0, occupancy=0, out_ctrl=CTRL_BUBBLE, out_data=0, skid contents=0. in_ready=0 while reset=0.
- All inputs are ignored in a reset cycle.

## Timing
- Latency: an entry accepted at edge N is on out_* after edge N (1 cycle) when the block was EMPTY or ONE with out_fire.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Back-pressure: after out_ready drops, at most one more entry is accepted (into the skid). in_ready falls the cycle after state reaches TWO.
- in_ready rises the cycle after the first out_fire from TWO.
- Outputs are fully registered; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- flush takes effect at the same edge. out_valid=0 in the following cycle; in_ready=1 in the following cycle (if reset=1).

## Test plan
- Reset: drive reset=0 for 2 cycles with in_valid=1, in_data=0xABCDEF. Required: out_valid=0, out_ctrl=CTRL_BUBBLE, occupancy=0, in_ready=0. Release reset: in_ready=1 next cycle.
- Streaming: out_ready=1, push 0x000001..0x000010 on consecutive cycles with in_ctrl=4'b1101. Required: the same sequence appears in order, 1 cycle later, and occupancy never exceeds 1.
- Back-pressure: push A, B, C with out_ready=0. Required: A in main, B in skid, occupancy=2, in_ready=0, C not accepted. Raise out_ready: outputs A, B, then C after re-acceptance, with no loss or duplication.
- Flush: hold occupancy=2 with in_valid=1 and assert flush for 1 cycle. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, and the same-cycle input is absent from the output.
- Flush with simultaneous out_fire: in ONE with out_ready=1 and flush=1. Required: the entry is counted as consumed and the state is EMPTY.
- Random: random in_valid/out_ready/flush for 10k cycles against a FIFO scoreboard. Required: order preserved, out_ctrl==CTRL_BUBBLE whenever out_valid=0, and occupancy matches the model.
